mul_iter_unit: RTL

- Iterative radix-2 shift-add multiplier for the RV32 MUL instruction (opcode OP_ALU, funct7 F7_MUL, funct3 F3_MUL); returns the low 32 bits of the product.
- Sits beside the single-cycle ALU in the execute stage. The pipeline hands it operands through a valid/ready request port and collects the result through a valid/ready response port.
- Holds one operation at a time, exposes busy status for stall logic, and drops its work on a pipeline flush.

---
 rtl/tartaruga_pkg.sv | 26 ++
 rtl/mul_iter_unit_if.sv | 32 +++
 rtl/mul_shift_add_step.sv | 34 +++
 rtl/mul_iter_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - shared types and constants for the iterative multiplier
// Purpose: FSM state encoding, default widths and request/response bundles.
// Ports: none (package).
package tartaruga_pkg;

   localparam int MUL_XLEN  = 32;
   localparam int MUL_TAG_W = 5;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_BUSY,
      MUL_DONE
   } mul_state_t;

   typedef struct packed {
      logic [MUL_XLEN-1:0]  rs1;
      logic [MUL_XLEN-1:0]  rs2;
      logic [MUL_TAG_W-1:0] tag;
   } mul_req_t;

   typedef struct packed {
      logic [MUL_XLEN-1:0]  result;
      logic [MUL_TAG_W-1:0] tag;
   } mul_rsp_t;

endpackage

// File: rtl/mul_iter_unit_if.sv
// rtl/mul_iter_unit_if.sv - request/response handshake bundle of the multiplier
// Purpose: groups the valid/ready request and response channels.
// Ports (signals):
//   req_valid_i, req_ready_o, req_rs1_i, req_rs2_i, req_tag_i  request channel
//   rsp_valid_o, rsp_ready_i, rsp_result_o, rsp_tag_o          response channel
// Modports: slave = multiplier side, master = pipeline side.
interface mul_iter_unit_if import tartaruga_pkg::*; #(
   parameter int XLEN  = MUL_XLEN,
   parameter int TAG_W = MUL_TAG_W
);

   logic             req_valid_i;
   logic             req_ready_o;
   logic [XLEN-1:0]  req_rs1_i;
   logic [XLEN-1:0]  req_rs2_i;
   logic [TAG_W-1:0] req_tag_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [XLEN-1:0]  rsp_result_o;
   logic [TAG_W-1:0] rsp_tag_o;

   modport slave (
      input  req_valid_i, req_rs1_i, req_rs2_i, req_tag_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o
   );

   modport master (
      output req_valid_i, req_rs1_i, req_rs2_i, req_tag_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o
   );

endinterface

// File: rtl/mul_shift_add_step.sv
// rtl/mul_shift_add_step.sv - one combinational radix-2 shift-add iteration
// Purpose: computes the next accumulator/multiplicand/multiplier and flags the last iteration.
// Ports:
//   acc, mcand, mplier   current datapath state
//   count                iterations already completed
//   acc_next, mcand_next, mplier_next   state after this iteration
//   last                 this iteration finishes the operation
module mul_shift_add_step import tartaruga_pkg::*; #(
   parameter int XLEN       = MUL_XLEN,
   parameter int EARLY_TERM = 1,
   localparam int CNT_W     = $clog2(XLEN)
) (
   input  logic [XLEN-1:0]  acc,
   input  logic [XLEN-1:0]  mcand,
   input  logic [XLEN-1:0]  mplier,
   input  logic [CNT_W-1:0] count,
   output logic [XLEN-1:0]  acc_next,
   output logic [XLEN-1:0]  mcand_next,
   output logic [XLEN-1:0]  mplier_next,
   output logic             last
);

   always_comb begin
      // Carry-out is dropped: only the low XLEN bits of the product are kept.
      acc_next    = mplier[0] ? (acc + mcand) : acc;
      mcand_next  = mcand << 1;
      mplier_next = mplier >> 1;
      // Early exit looks at the shifted multiplier so the iteration that
      // consumes the top set bit is the final one.
      last        = (count == CNT_W'(XLEN - 1)) ||
                    ((EARLY_TERM != 0) && (mplier_next == '0));
   end

endmodule

// File: rtl/mul_iter_unit.sv
// rtl/mul_iter_unit.sv - iterative shift-add multiplier returning product[XLEN-1:0]
// Purpose: one operation at a time, IDLE -> BUSY (one iteration per cycle) -> DONE.
// Ports:
//   clk_i    clock
//   rstn_i   asynchronous active-low reset
//   flush_i  drops the in-flight operation, no response; blocks acceptance in IDLE
//   busy_o   state is not IDLE (stall source)
//   bus      request/response handshake (slave side)
module mul_iter_unit import tartaruga_pkg::*; #(
   parameter int XLEN       = MUL_XLEN,
   parameter int TAG_W      = MUL_TAG_W,
   parameter int EARLY_TERM = 1
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   input  logic           flush_i,
   output logic           busy_o,
   mul_iter_unit_if.slave bus
);

   localparam int CNT_W = $clog2(XLEN);

   mul_state_t       state_q, state_d;
   logic [XLEN-1:0]  acc_q, mcand_q, mplier_q;
   logic [CNT_W-1:0] count_q;
   logic [TAG_W-1:0] tag_q;

   logic [XLEN-1:0]  acc_nx, mcand_nx, mplier_nx;
   logic             last;
   logic             load, step;

   mul_shift_add_step #(
      .XLEN       (XLEN),
      .EARLY_TERM (EARLY_TERM)
   ) u_step (
      .acc         (acc_q),
      .mcand       (mcand_q),
      .mplier      (mplier_q),
      .count       (count_q),
      .acc_next    (acc_nx),
      .mcand_next  (mcand_nx),
      .mplier_next (mplier_nx),
      .last        (last)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= MUL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush wins over both completion and the response handshake.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (bus.req_valid_i && !flush_i) begin
               load    = 1'b1;
               state_d = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            if (flush_i) begin
               state_d = MUL_IDLE;
            end else begin
               step = 1'b1;
               if (last) begin
                  state_d = MUL_DONE;
               end
            end
         end
         MUL_DONE: begin
            if (flush_i || bus.rsp_ready_i) begin
               state_d = MUL_IDLE;
            end
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         tag_q    <= '0;
      end else if (load) begin
         acc_q    <= '0;
         mcand_q  <= bus.req_rs1_i;
         mplier_q <= bus.req_rs2_i;
         count_q  <= '0;
         tag_q    <= bus.req_tag_i;
      end else if (step) begin
         acc_q    <= acc_nx;
         mcand_q  <= mcand_nx;
         mplier_q <= mplier_nx;
         count_q  <= count_q + CNT_W'(1);
      end
   end

   // acc and tag only change on load/step, so they are stable throughout DONE.
   assign bus.req_ready_o  = (state_q == MUL_IDLE);
   assign bus.rsp_valid_o  = (state_q == MUL_DONE);
   assign bus.rsp_result_o = acc_q;
   assign bus.rsp_tag_o    = tag_q;
   assign busy_o           = (state_q != MUL_IDLE);

endmodule
